// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way request arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational winner selection: fixed priority (highest index wins) or
// round robin (first set bit at or after start, ascending with wrap).
module arb_prio_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    start,
  input  logic               mode,
  output logic [ID_W-1:0]    win,
  output logic               any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    win = '0;
    idx = '0;
    any = |req;
    if (mode) begin
      // Walk the ring backwards so the closest set bit to start is written last.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = start + ID_W'(k);
        if (req[idx]) win = idx;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i]) win = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester arbiter with fixed/round-robin selection, bounded hold time
// and a one-cycle release gap between grants.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no owner; any request is granted at the next edge
//   GRANT   | one owner holds gnt until done, request drop or hold limit
//   RELEASE | one-cycle gap, last_id updated for round-robin fairness
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mode,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_e         state_q, state_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [ID_W-1:0]    gnt_id_d;
  logic               busy_d;
  logic               timeout_d;

  logic [ID_W-1:0]    pick_start;
  logic [ID_W-1:0]    pick_win;
  logic               pick_any;
  logic               owner_req;
  logic               hold_hit;

  assign pick_start = last_id_q + 1'b1;
  assign owner_req  = req[gnt_id];
  assign hold_hit   = (hold_cnt_q == HOLD_LAST);

  arb_prio_pick u_pick (
    .req   (req),
    .start (pick_start),
    .mode  (mode),
    .win   (pick_win),
    .any   (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_id_d  = last_id_q;
    gnt_d      = gnt;
    gnt_id_d   = gnt_id;
    busy_d     = busy;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_any) begin
          state_d    = GRANT;
          gnt_d      = id2onehot(pick_win);
          gnt_id_d   = pick_win;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end
      end

      GRANT: begin
        if (done || !owner_req || hold_hit) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          // Only a pure hold-limit exit counts as a timeout.
          timeout_d = !done && owner_req && hold_hit;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      RELEASE: begin
        state_d   = IDLE;
        last_id_d = gnt_id;
        gnt_d     = '0;
        busy_d    = 1'b0;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      last_id_q  <= 2'd3;
      gnt        <= '0;
      gnt_id     <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_id_q  <= last_id_d;
      gnt        <= gnt_d;
      gnt_id     <= gnt_id_d;
      busy       <= busy_d;
      timeout    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: fixed/round-robin order, timeout,
// dropped request, done/limit collision, no preemption, mid-grant reset.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       mode;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_chk  = 0;
  int n_pass = 0;

  rr_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mode    (mode),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] rr_order [5];
  logic [3:0] oh;

  initial begin
    rr_order[0] = 2'd0; rr_order[1] = 2'd1; rr_order[2] = 2'd2;
    rr_order[3] = 2'd3; rr_order[4] = 2'd0;

    rst_n = 1'b0; req = 4'b0000; mode = 1'b0; done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_gnt", 8'(gnt), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_id", 8'(gnt_id), 8'h0);
    chk("rst_tmo", 8'(timeout), 8'h0);

    // Fixed priority: highest index wins, then lower once it is dropped
    req = 4'b1010;
    tick();
    chk("fx_gnt", 8'(gnt), 8'h08);
    chk("fx_id", 8'(gnt_id), 8'h3);
    chk("fx_busy", 8'(busy), 8'h1);
    done = 1'b1; req = 4'b0010;
    tick();
    chk("fx_rel_gnt", 8'(gnt), 8'h0);
    chk("fx_rel_busy", 8'(busy), 8'h0);
    chk("fx_rel_tmo", 8'(timeout), 8'h0);
    done = 1'b0;
    tick();
    chk("fx_idle_gnt", 8'(gnt), 8'h0);
    tick();
    chk("fx_gnt2", 8'(gnt), 8'h02);
    chk("fx_id2", 8'(gnt_id), 8'h1);
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0000;
    tick();
    tick();
    chk("idle_noreq_gnt", 8'(gnt), 8'h0);
    chk("idle_noreq_busy", 8'(busy), 8'h0);

    // Round robin from reset: order 0,1,2,3,0 with 2-cycle gaps
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mode = 1'b1; req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      oh = 4'b0001 << rr_order[n];
      chk($sformatf("rr_gnt%0d", n), 8'(gnt), 8'(oh));
      chk($sformatf("rr_id%0d", n), 8'(gnt_id), 8'(rr_order[n]));
      done = 1'b1;
      tick();
      chk($sformatf("rr_rel%0d", n), 8'(busy), 8'h0);
      done = 1'b0;
      tick();
      chk($sformatf("rr_gap%0d", n), 8'(gnt), 8'h0);
      tick();
    end
    // Owner (index 1) drops its request: release without timeout
    chk("drop_own", 8'(gnt_id), 8'h1);
    req = 4'b0000;
    tick();
    chk("drop_busy", 8'(busy), 8'h0);
    chk("drop_tmo", 8'(timeout), 8'h0);
    tick();

    // Hold-limit timeout: busy 8 cycles, 1-cycle timeout, re-grant
    mode = 1'b0; req = 4'b0100;
    tick();
    chk("to_gnt", 8'(gnt), 8'h04);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("to_busy%0d", i), 8'(busy), 8'h1);
      chk($sformatf("to_quiet%0d", i), 8'(timeout), 8'h0);
    end
    tick();
    chk("to_rel_busy", 8'(busy), 8'h0);
    chk("to_pulse", 8'(timeout), 8'h1);
    tick();
    chk("to_pulse_end", 8'(timeout), 8'h0);
    tick();
    chk("to_regrant", 8'(gnt), 8'h04);
    chk("to_regrant_id", 8'(gnt_id), 8'h2);

    // Higher request mid-grant is ignored; done collides with hold limit
    req = 4'b1100;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("np_gnt%0d", i), 8'(gnt), 8'h04);
    end
    done = 1'b1;
    tick();
    chk("col_busy", 8'(busy), 8'h0);
    chk("col_tmo", 8'(timeout), 8'h0);
    done = 1'b0;
    tick();
    tick();
    chk("col_next", 8'(gnt), 8'h08);

    // Reset during GRANT clears outputs at that edge, RR restarts at 0
    rst_n = 1'b0;
    tick();
    chk("mr_gnt", 8'(gnt), 8'h0);
    chk("mr_busy", 8'(busy), 8'h0);
    chk("mr_id", 8'(gnt_id), 8'h0);
    chk("mr_tmo", 8'(timeout), 8'h0);
    rst_n = 1'b1; mode = 1'b1; req = 4'b1111;
    tick();
    chk("mr_tmo2", 8'(timeout), 8'h0);
    chk("mr_rr_gnt", 8'(gnt), 8'h01);
    chk("mr_rr_id", 8'(gnt_id), 8'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 8, is the maximum number of cycles one grant may be held before forced release (legal range 2..255).
REQ-002 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1, is the reset: synchronous and active-low.
REQ-004 Port req, input, 4, carries the request lines {req3, req2, req1, req0}, level-sensitive.
REQ-005 Port mode, input, 1, selects arbitration: 0 = fixed priority (req3 highest), 1 = round robin.
REQ-006 Port done, input, 1, is a release strobe from the current owner, sampled only in GRANT.
REQ-007 Port gnt, output, 4, is the registered one-hot grant vector.
REQ-008 Port gnt_id, output, 2, is the registered binary index of the owner; valid only while busy=1.
REQ-009 Port busy, output, 1, is registered and high while in GRANT.
REQ-010 Port timeout, output, 1, is a registered one-cycle pulse when a grant is force-released.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and RELEASE.
REQ-012 IDLE with req != 0 SHALL move to GRANT at the next edge, loading gnt, gnt_id and busy=1 in that edge, so grant latency is 1 cycle from sampled request.
REQ-013 IDLE with req == 0 SHALL stay in IDLE with gnt=0.
REQ-014 In fixed mode, the winner SHALL be the highest set index of req.
REQ-015 In round-robin mode, the search SHALL start at (last_id+1) mod 4, proceed ascending with wrap-around, and pick the first set bit.
REQ-016 mode SHALL be sampled only at the IDLE->GRANT decision; changing it mid-grant has no effect on the current owner.
REQ-017 The GRANT state SHALL exit to RELEASE at the next edge when done=1, or when req[gnt_id]=0, or when hold_cnt == MAX_HOLD-1.
REQ-018 hold_cnt SHALL be 8 bits, clear on GRANT entry, and increment each GRANT cycle; it SHALL never wrap.
REQ-019 timeout SHALL be 1 in the RELEASE cycle only if the exit was caused by hold_cnt and not by done or a dropped request; done takes precedence when both occur in the same cycle.
REQ-020 Requests from non-owners during GRANT SHALL be ignored; no preemption occurs, even by a higher fixed priority.
REQ-021 RELEASE SHALL last exactly one cycle with gnt=0 and busy=0, update last_id to the released gnt_id, then go to IDLE.
REQ-022 The idle gap between consecutive grants SHALL be 2 cycles (RELEASE, then IDLE decision).
REQ-023 gnt SHALL always be one-hot or zero; gnt != 0 if and only if busy=1.

Reset
REQ-024 While rst_n=0 at an edge, the block SHALL set state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, hold_cnt=0 and last_id=3, so the first round-robin search starts at index 0.
REQ-025 Reset asserted mid-grant SHALL drop gnt at that same edge with no RELEASE cycle and no timeout pulse.

Structure
REQ-026 A shared package arb_pkg SHALL hold the state encoding (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2), NUM_REQ=4 and ID_W=2.
REQ-027 A combinational sub-module arb_prio_pick SHALL take req, a start index and mode, and return the winner index plus an any-request flag.
REQ-028 The top level SHALL contain only the FSM, hold_cnt, last_id and the output registers.

Verification
REQ-029 Reset then req=4'b1010, mode=0: gnt=4'b1000 and gnt_id=3 one cycle later; done=1 gives RELEASE, then gnt=4'b0010 two cycles after that.
REQ-030 Round robin: req=4'b1111 held, done pulsed each grant: grant order is 0,1,2,3,0 with a 2-cycle gap between grants.
REQ-031 Timeout: req=4'b0100 held, done=0, MAX_HOLD=8: busy high for exactly 8 cycles, then timeout=1 for 1 cycle, then the grant to index 2 is re-issued.
REQ-032 Dropped request: the owner deasserts req mid-grant: RELEASE at the next edge with timeout=0.
REQ-033 Simultaneous events: done=1 on the same cycle hold_cnt=MAX_HOLD-1: timeout stays 0, and a higher request arriving mid-grant causes no preemption.
REQ-034 Reset mid-operation: rst_n=0 during GRANT: all outputs are 0 at that edge, and after release the first round-robin grant with req=4'b1111 goes to index 0.
